// File: rtl/xocc_port.sv
// xocc_port: core-side endpoint of the xocc command/response link.
// Command FIFO toward the bridge, response FIFO toward the core, outstanding tracking.
module xocc_port #(
  parameter int CMD_WIDTH       = 32,
  parameter int RSP_WIDTH       = 32,
  parameter int CMD_AW          = 2,
  parameter int RSP_AW          = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int RSP_FULL_MARGIN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 core_cmd_valid,
  input  logic [CMD_WIDTH-1:0] core_cmd_data,
  output logic                 core_cmd_ready,
  output logic                 core_rsp_valid,
  output logic [RSP_WIDTH-1:0] core_rsp_data,
  input  logic                 core_rsp_ready,
  output logic [CMD_WIDTH-1:0] xocc_cmd_buffer,
  output logic                 xocc_cmd_empty,
  input  logic                 xocc_cmd_rd_en,
  input  logic [RSP_WIDTH-1:0] xocc_rsp_buffer,
  input  logic                 xocc_rsp_wr_en,
  output logic                 xocc_rsp_full,
  output logic [7:0]           outstanding,
  input  logic                 err_clr,
  output logic                 err_underflow,
  output logic                 err_overflow,
  output logic                 err_unexpected
);

  localparam int CMD_DEPTH = 2 ** CMD_AW;
  localparam int RSP_DEPTH = 2 ** RSP_AW;
  localparam logic [CMD_AW:0] CMD_MAX = (CMD_AW+1)'(CMD_DEPTH);
  localparam logic [RSP_AW:0] RSP_MAX = (RSP_AW+1)'(RSP_DEPTH);
  localparam logic [7:0] OUT_MAX = 8'(MAX_OUTSTANDING);

  logic [CMD_WIDTH-1:0] cmd_mem [CMD_DEPTH];
  logic [CMD_AW-1:0]    cmd_wp, cmd_rp;
  logic [CMD_AW:0]      cmd_cnt, cmd_cnt_nxt;
  logic                 cmd_push, cmd_pop;

  logic [RSP_WIDTH-1:0] rsp_mem [RSP_DEPTH];
  logic [RSP_AW-1:0]    rsp_wp, rsp_rp;
  logic [RSP_AW:0]      rsp_cnt, rsp_cnt_nxt;
  logic [RSP_AW:0]      rsp_free_nxt;
  logic                 rsp_push, rsp_pop;

  logic [7:0] out_nxt;
  logic       out_dec;

  assign core_cmd_ready = ~rst & (cmd_cnt < CMD_MAX)
                        & (outstanding < OUT_MAX);
  assign cmd_push = core_cmd_valid & core_cmd_ready;
  assign cmd_pop  = xocc_cmd_rd_en & ~xocc_cmd_empty;

  assign xocc_cmd_empty  = (cmd_cnt == '0);
  assign xocc_cmd_buffer = xocc_cmd_empty ? '0 : cmd_mem[cmd_rp];

  assign core_rsp_valid = (rsp_cnt != '0);
  assign core_rsp_data  = core_rsp_valid ? rsp_mem[rsp_rp] : '0;
  assign rsp_push = xocc_rsp_wr_en & (rsp_cnt != RSP_MAX);
  assign rsp_pop  = core_rsp_valid & core_rsp_ready;

  assign out_dec = rsp_push & (outstanding != 8'd0);

  always_comb begin
    cmd_cnt_nxt = cmd_cnt;
    case ({cmd_push, cmd_pop})
      2'b10:   cmd_cnt_nxt = cmd_cnt + 1'b1;
      2'b01:   cmd_cnt_nxt = cmd_cnt - 1'b1;
      default: cmd_cnt_nxt = cmd_cnt;
    endcase
  end

  always_comb begin
    rsp_cnt_nxt = rsp_cnt;
    case ({rsp_push, rsp_pop})
      2'b10:   rsp_cnt_nxt = rsp_cnt + 1'b1;
      2'b01:   rsp_cnt_nxt = rsp_cnt - 1'b1;
      default: rsp_cnt_nxt = rsp_cnt;
    endcase
  end

  assign rsp_free_nxt = RSP_MAX - rsp_cnt_nxt;

  always_comb begin
    out_nxt = outstanding;
    case ({cmd_push, out_dec})
      2'b10:   out_nxt = outstanding + 8'd1;
      2'b01:   out_nxt = outstanding - 8'd1;
      default: out_nxt = outstanding;
    endcase
  end

  // Storage is not reset; the counts gate everything visible.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wp] <= core_cmd_data;
    if (rsp_push) rsp_mem[rsp_wp] <= xocc_rsp_buffer;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_wp <= '0;
      cmd_rp <= '0;
      cmd_cnt <= '0;
    end else begin
      if (cmd_push) cmd_wp <= cmd_wp + 1'b1;
      if (cmd_pop)  cmd_rp <= cmd_rp + 1'b1;
      cmd_cnt <= cmd_cnt_nxt;
    end
  end

  // Full is registered with margin so the bridge's late wr_en still fits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_wp <= '0;
      rsp_rp <= '0;
      rsp_cnt <= '0;
      xocc_rsp_full <= 1'b0;
    end else begin
      if (rsp_push) rsp_wp <= rsp_wp + 1'b1;
      if (rsp_pop)  rsp_rp <= rsp_rp + 1'b1;
      rsp_cnt <= rsp_cnt_nxt;
      xocc_rsp_full <= 32'(rsp_free_nxt) <= 32'(RSP_FULL_MARGIN);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= 8'd0;
      err_underflow <= 1'b0;
      err_overflow <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      outstanding <= out_nxt;
      err_underflow <= (xocc_cmd_rd_en & xocc_cmd_empty)
                     | (err_underflow & ~err_clr);
      err_overflow <= (xocc_rsp_wr_en & ~rsp_push)
                    | (err_overflow & ~err_clr);
      err_unexpected <= (rsp_push & (outstanding == 8'd0))
                      | (err_unexpected & ~err_clr);
    end
  end

endmodule
